// File: rtl/booth_mul_vr.sv
// Parametrised sequential radix-2 Booth multiplier with valid/ready on both sides.
// Operands are extended one bit and run WIDTH+1 steps so signed and unsigned share one datapath.
module booth_mul_vr #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_val,
  output logic                 src_ready,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic                 src_signed,
  output logic                 dest_val,
  input  logic                 dest_ready,
  output logic [2*WIDTH-1:0]   dest_product,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH+1:0]     m_q, m_d;
  logic [WIDTH+1:0]     acc_q, acc_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 accept;
  logic                 src_ready_c;
  logic [WIDTH+1:0]     ext_a;
  logic [WIDTH:0]       ext_b;
  logic [WIDTH+1:0]     sum;
  logic [WIDTH+1:0]     acc_sh;
  logic [WIDTH:0]       q_sh;

  // Multiplicand carries a guard bit on top of the extension so ACC +/- M cannot overflow.
  assign ext_a = src_signed ? {{2{src_a[WIDTH-1]}}, src_a} : {2'b00, src_a};
  assign ext_b = src_signed ? {src_b[WIDTH-1], src_b} : {1'b0, src_b};

  always_comb begin
    sum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  assign acc_sh = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_sh   = {sum[0], q_q[WIDTH:1]};

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    acc_d       = acc_q;
    q_d         = q_q;
    q1_d        = q1_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    accept      = 1'b0;
    src_ready_c = 1'b0;
    dest_val    = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        src_ready_c = 1'b1;
        accept      = src_val;
      end
      CALC: begin
        busy  = 1'b1;
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH)) begin
          // Low 2*WIDTH bits of the post-shift {ACC,Q}.
          prod_d  = {acc_sh[WIDTH-2:0], q_sh};
          state_d = DONE;
        end
      end
      DONE: begin
        dest_val    = 1'b1;
        src_ready_c = dest_ready;
        if (dest_ready) begin
          if (src_val) accept = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_d     = ext_a;
      q_d     = ext_b;
      acc_d   = '0;
      q1_d    = 1'b0;
      cnt_d   = '0;
      state_d = CALC;
    end
  end

  assign src_ready    = src_ready_c & ~rst;
  assign dest_product = prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_vr.sv
// Directed and randomised checks of booth_mul_vr at WIDTH 8, 4 and 16.
module tb_booth_mul_vr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        s8_val = 0, s8_rdy, s8_sg = 0, d8_val, d8_rdy = 0, b8;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic [15:0] d8_p;

  logic        s4_val = 0, s4_rdy, s4_sg = 0, d4_val, d4_rdy = 0, b4;
  logic [3:0]  s4_a = '0, s4_b = '0;
  logic [7:0]  d4_p;

  logic        s16_val = 0, s16_rdy, s16_sg = 0, d16_val, d16_rdy = 0, b16;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic [31:0] d16_p;

  booth_mul_vr #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .src_val(s8_val), .src_ready(s8_rdy), .src_a(s8_a), .src_b(s8_b),
    .src_signed(s8_sg), .dest_val(d8_val), .dest_ready(d8_rdy), .dest_product(d8_p), .busy(b8));

  booth_mul_vr #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .src_val(s4_val), .src_ready(s4_rdy), .src_a(s4_a), .src_b(s4_b),
    .src_signed(s4_sg), .dest_val(d4_val), .dest_ready(d4_rdy), .dest_product(d4_p), .busy(b4));

  booth_mul_vr #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .src_val(s16_val), .src_ready(s16_rdy), .src_a(s16_a), .src_b(s16_b),
    .src_signed(s16_sg), .dest_val(d16_val), .dest_ready(d16_rdy), .dest_product(d16_p), .busy(b16));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input int w, input logic [63:0] a,
                                           input logic [63:0] b, input bit s);
    longint ea, eb, p;
    logic [127:0] r;
    ea = longint'(a & ((64'd1 << w) - 64'd1));
    eb = longint'(b & ((64'd1 << w) - 64'd1));
    if (s && a[w-1]) ea = ea - (longint'(1) << w);
    if (s && b[w-1]) eb = eb - (longint'(1) << w);
    p = ea * eb;
    r = 128'(p);
    return r & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    @(negedge clk);
    s8_a = a; s8_b = b; s8_sg = sg; s8_val = 1'b1;
    #1 chk("accept_ready", s8_rdy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    s8_val = 1'b0;
    s8_a = ~a; s8_b = ~b; s8_sg = ~sg;
  endtask

  // Returns number of edges after the accept edge until dest_val is seen (0 = timeout).
  task automatic wait_done8(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        chk("calc_busy", b8, 1'b1);
        chk("calc_src_ready", s8_rdy, 1'b0);
      end
      if (d8_val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic handshake8();
    @(negedge clk);
    d8_rdy = 1'b1;
    @(posedge clk);
    #1 d8_rdy = 1'b0;
    chk("post_hs_dest_val", d8_val, 1'b0);
    chk("post_hs_idle_ready", s8_rdy, 1'b1);
    chk("post_hs_busy", b8, 1'b0);
  endtask

  task automatic run_one8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sg, input logic [15:0] exp);
    int n;
    accept8(a, b, sg);
    wait_done8(n);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_product"}, d8_p, exp);
    handshake8();
  endtask

  task automatic sweep4();
    logic [7:0]   q[$];
    logic [127:0] e;
    int acc_n = 0, got_n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      s4_val = (c < 350) ? 1'($urandom_range(0, 1)) : 1'b0;
      d4_rdy = (c < 350) ? 1'($urandom_range(0, 1)) : 1'b1;
      s4_a = 4'($urandom); s4_b = 4'($urandom); s4_sg = 1'($urandom);
      #1;
      if (s4_val && s4_rdy) begin
        e = ref_mul(4, 64'(s4_a), 64'(s4_b), s4_sg);
        q.push_back(e[7:0]);
        acc_n++;
      end
      if (d4_val && d4_rdy) begin
        got_n++;
        if (q.size() == 0) chk("w4_extra_product", got_n, acc_n);
        else               chk("w4_product", d4_p, q.pop_front());
      end
    end
    chk("w4_count", got_n, acc_n);
    chk("w4_pending", q.size(), 0);
  endtask

  task automatic sweep16();
    logic [31:0]  q[$];
    logic [127:0] e;
    int acc_n = 0, got_n = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      s16_val = (c < 720) ? 1'($urandom_range(0, 1)) : 1'b0;
      d16_rdy = (c < 720) ? 1'($urandom_range(0, 1)) : 1'b1;
      s16_a = 16'($urandom); s16_b = 16'($urandom); s16_sg = 1'($urandom);
      #1;
      if (s16_val && s16_rdy) begin
        e = ref_mul(16, 64'(s16_a), 64'(s16_b), s16_sg);
        q.push_back(e[31:0]);
        acc_n++;
      end
      if (d16_val && d16_rdy) begin
        got_n++;
        if (q.size() == 0) chk("w16_extra_product", got_n, acc_n);
        else               chk("w16_product", d16_p, q.pop_front());
      end
    end
    chk("w16_count", got_n, acc_n);
    chk("w16_pending", q.size(), 0);
  endtask

  logic [7:0]  b2b_a [4] = '{8'h12, 8'h7F, 8'h81, 8'hFF};
  logic [7:0]  b2b_b [4] = '{8'hF0, 8'h7F, 8'h05, 8'h80};
  logic [15:0] b2b_e [4] = '{16'hFEE0, 16'h3F01, 16'hFD85, 16'h0080};

  initial begin
    int n, k, last, seen;

    // Reset state
    #12;
    chk("rst_dest_val", d8_val, 1'b0);
    chk("rst_busy", b8, 1'b0);
    chk("rst_product", d8_p, 16'h0000);
    chk("rst_w16_product", d16_p, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", s8_rdy, 1'b1);
    chk("post_rst_w4_ready", s4_rdy, 1'b1);

    // Directed products
    run_one8("signed_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    run_one8("unsigned_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_one8("signed_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_one8("signed_80x7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
    run_one8("signed_ffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);

    // Back-pressure: 7*6 held for 20 cycles while src_val pulses
    accept8(8'h07, 8'h06, 1'b0);
    wait_done8(n);
    chk("bp_latency", n, 9);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s8_val = c[0];
      s8_a = 8'h55; s8_b = 8'h33; s8_sg = 1'b1;
      #1;
      chk("bp_dest_val", d8_val, 1'b1);
      chk("bp_product", d8_p, 16'h002A);
      chk("bp_src_ready", s8_rdy, 1'b0);
    end
    @(negedge clk);
    s8_val = 1'b0;
    d8_rdy = 1'b1;
    @(posedge clk);
    #1 d8_rdy = 1'b0;
    chk("bp_release_dest_val", d8_val, 1'b0);
    chk("bp_release_idle", s8_rdy, 1'b1);
    chk("bp_release_busy", b8, 1'b0);
    chk("bp_product_kept", d8_p, 16'h002A);

    // Back-to-back signed stream, src_val and dest_ready held high
    @(negedge clk);
    s8_a = b2b_a[0]; s8_b = b2b_b[0]; s8_sg = 1'b1;
    s8_val = 1'b1; d8_rdy = 1'b1;
    k = 0; last = 0;
    for (int cyc = 0; cyc < 80 && k < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (d8_val) begin
        chk("b2b_product", d8_p, b2b_e[k]);
        if (k > 0) chk("b2b_period", cyc - last, 10);
        last = cyc;
        k++;
        if (k < 4) begin
          s8_a = b2b_a[k]; s8_b = b2b_b[k];
        end else begin
          s8_val = 1'b0;
        end
      end
    end
    chk("b2b_results", k, 4);
    @(posedge clk);
    #1 d8_rdy = 1'b0;
    chk("b2b_end_idle", s8_rdy, 1'b1);

    // Reset mid-CALC
    accept8(8'h03, 8'h03, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", b8, 1'b0);
    chk("midrst_dest_val", d8_val, 1'b0);
    chk("midrst_product", d8_p, 16'h0000);
    chk("midrst_src_ready", s8_rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    d8_rdy = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (d8_val) seen = 1;
    end
    d8_rdy = 1'b0;
    chk("midrst_no_pulse", seen, 0);
    run_one8("after_rst", 8'hF6, 8'h0C, 1'b1, 16'hFF88);

    // Randomised sweeps
    sweep4();
    sweep16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mul_vr.md
Name: booth_mul_vr

Overview:
- Self-contained, parametrised sequential radix-2 Booth multiplier.
- Controller, datapath and iteration counter are integrated in one module.
- Valid/ready handshake on both the source side and the destination side.
- Successor to the fixed-width Booth controller. Adds:
  - a WIDTH parameter;
  - a per-transaction signed/unsigned mode;
  - a registered, back-pressure-stable result;
  - acceptance of the next operands in the same cycle the current result is taken.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+2), iteration counter width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- src_val  input  1  source operands valid.
- src_ready  output  1  block can accept operands.
- src_a  input  WIDTH  multiplicand.
- src_b  input  WIDTH  multiplier.
- src_signed  input  1  1 = both operands are two's complement; 0 = both unsigned. Sampled with the operands.
- dest_val  output  1  product valid.
- dest_ready  input  1  sink accepts product.
- dest_product  output  2*WIDTH  product.
- busy  output  1  high while in CALC.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE;
  - dest_val = 0, dest_product = 0, busy = 0;
  - counter and all internal registers = 0.
  - src_ready = 1 from the first cycle after reset deassertion.
  - Reset asserted mid-CALC or mid-DONE aborts the operation; the result is discarded and never presented.
- Operand extension at accept: src_a and src_b are extended to WIDTH+1 bits, sign-extended if src_signed = 1, zero-extended otherwise.
  - Internally everything is signed Booth.
  - One extra iteration is run, so both modes share one datapath.
- Datapath registers:
  - M = extended multiplicand, WIDTH+2 bits including one guard bit. Add/subtract never overflows.
  - ACC, WIDTH+2 bits.
  - Q = extended multiplier, WIDTH+1 bits.
  - q_1, 1 bit.
  - CNT, CNT_W bits.
- States and transitions:
  - IDLE:
    - src_ready = 1, dest_val = 0.
    - src_val & src_ready → load M and Q; ACC = 0, q_1 = 0, CNT = 0; go to CALC.
  - CALC:
    - src_ready = 0, busy = 1.
    - Each cycle, on {Q[0],q_1}: 01 → ACC += M; 10 → ACC -= M; 00/11 → no change.
    - Then arithmetic-shift {ACC,Q,q_1} right by 1. CNT += 1.
    - When CNT == WIDTH (the (WIDTH+1)-th step), the same edge loads dest_product with the low 2*WIDTH bits of the post-shift {ACC,Q} and goes to DONE.
  - DONE:
    - dest_val = 1. dest_product is held stable while dest_val & !dest_ready.
    - src_ready = dest_ready (combinational).
    - dest_ready & src_val → accept new operands on that edge, go to CALC directly; dest_val is low the next cycle.
    - dest_ready & !src_val → go to IDLE.
    - !dest_ready → stay in DONE. src_val is ignored and no operand is captured.
- Timing:
  - Latency: operands accepted at edge T; dest_val rises after edge T+WIDTH+1.
  - Back-to-back throughput: one result per WIDTH+2 cycles.
- Operand and output stability:
  - src_a, src_b and src_signed are sampled only on the accept edge. Later changes have no effect.
  - dest_product keeps its last value after the handshake until overwritten by the next completion.
- Output decoding:
  - dest_val, src_ready and busy are decoded from state; src_ready additionally uses dest_ready in DONE.
  - No output is X or Z in any state.
- An illegal state encoding recovers to IDLE on the next edge with all outputs deasserted.

Test Plan:
- WIDTH=8, signed, a=-3 (0xFD), b=5 → dest_val exactly 9 cycles after accept, dest_product=0xFFF1.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → dest_product=0xFE01. Repeat signed with a=0x80, b=0x80 → 0x4000; signed a=0x80, b=0x7F → 0xC080.
- Back-pressure: hold dest_ready=0 for 20 cycles after completion.
  - dest_val stays 1, dest_product is constant, src_ready=0, and src_val pulses are ignored.
  - Release → one handshake, then IDLE.
- Back-to-back: src_val and dest_ready tied high, 4 random signed pairs.
  - A new accept occurs on each result handshake; period is 10 cycles.
  - All products match the reference model.
- Reset mid-CALC: assert rst 4 cycles after accept.
  - Outputs are immediately 0 and dest_val never pulses for that operation.
  - The next transaction after release produces the correct product.
- Randomised sweep, WIDTH=4 and WIDTH=16, random mode and random src_val/dest_ready duty.
  - Scoreboard: every accepted pair yields exactly one product, in order, with no drop or duplicate.
